// File: rtl/mac_tx.sv
// mac_tx: GMII transmit MAC. Wraps a frame already held in a banked RAM with
// preamble, SFD, zero padding up to the 60-byte minimum, CRC-32 FCS and the
// inter-frame gap. Emits one byte per cycle with registered outputs.
module mac_tx (
  input  logic        clk,
  input  logic        RST,
  input  logic        udp_send,
  input  logic        rd_bank,
  input  logic [15:0] frame_len,
  output logic [10:0] rdaddr,
  input  logic [15:0] rd_data,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en,
  output logic        mac_busy
);

  localparam logic [10:0] MAX_LEN = 11'd1514;
  localparam logic [11:0] MIN_LEN = 12'd60;

  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG} state_t;

  // Reflected CRC-32 (0xEDB88320 is 0x04C11DB7 bit-reversed), one byte, LSB first
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] len_q, len_d;
  logic        bank_q, bank_d;
  logic [9:0]  word_q, word_d;
  logic [7:0]  lo_q, lo_d;
  logic [31:0] crc_q, crc_d;
  logic [7:0]  txd_q, txd_d;
  logic        en_q, en_d;
  logic        busy_q, busy_d;

  logic        start;
  logic [11:0] nxt_idx;
  logic [10:0] len_in;
  logic [1:0]  fcs_sel;

  assign start   = sync_q[1] & ~sync_q[2];
  assign nxt_idx = {1'b0, cnt_q} + 12'd1;
  assign len_in  = (frame_len > {5'd0, MAX_LEN}) ? MAX_LEN : frame_len[10:0];
  assign fcs_sel = cnt_q[1:0] + 2'd1;

  assign rdaddr     = {bank_q, word_q};
  assign gmii_txd   = txd_q;
  assign gmii_tx_en = en_q;
  assign mac_busy   = busy_q;

  // Next-state logic: chooses the byte that will be on the wire after this edge
  always_comb begin
    state_d = state_q;
    sync_d  = {sync_q[1:0], udp_send};
    cnt_d   = cnt_q;
    len_d   = len_q;
    bank_d  = bank_q;
    word_d  = word_q;
    lo_d    = lo_q;
    crc_d   = crc_q;
    txd_d   = txd_q;
    en_d    = en_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = PREAMBLE;
          len_d   = len_in;
          bank_d  = rd_bank;
          word_d  = 10'd0;   // word 0 is fetched while the preamble goes out
          crc_d   = 32'hFFFF_FFFF;
          cnt_d   = 11'd0;
          txd_d   = 8'h55;
          en_d    = 1'b1;
          busy_d  = 1'b1;
        end
      end
      PREAMBLE: begin
        if (cnt_q == 11'd6) begin
          state_d = SFD;
          cnt_d   = 11'd0;
          txd_d   = 8'hD5;
        end else begin
          cnt_d = nxt_idx[10:0];
        end
      end
      SFD: begin
        cnt_d = 11'd0;
        if (len_q == 11'd0) begin
          state_d = PAD;
          txd_d   = 8'h00;
        end else begin
          state_d = DATA;
          txd_d   = rd_data[15:8];
          lo_d    = rd_data[7:0];
          if ({1'b0, len_q} > 12'd2) word_d = word_q + 10'd1;
        end
        crc_d = crc32_byte(crc_q, txd_d);
      end
      DATA: begin
        if (nxt_idx < {1'b0, len_q}) begin
          cnt_d = nxt_idx[10:0];
          if (!nxt_idx[0]) begin
            txd_d = rd_data[15:8];
            lo_d  = rd_data[7:0];
            // Only prefetch a word that will actually be sent
            if ((nxt_idx + 12'd2) < {1'b0, len_q}) word_d = word_q + 10'd1;
          end else begin
            txd_d = lo_q;
          end
          crc_d = crc32_byte(crc_q, txd_d);
        end else if (nxt_idx < MIN_LEN) begin
          state_d = PAD;
          cnt_d   = nxt_idx[10:0];
          txd_d   = 8'h00;
          crc_d   = crc32_byte(crc_q, 8'h00);
        end else begin
          state_d = FCS;
          cnt_d   = 11'd0;
          txd_d   = ~crc_q[7:0];
        end
      end
      PAD: begin
        if (nxt_idx < MIN_LEN) begin
          cnt_d = nxt_idx[10:0];
          txd_d = 8'h00;
          crc_d = crc32_byte(crc_q, 8'h00);
        end else begin
          state_d = FCS;
          cnt_d   = 11'd0;
          txd_d   = ~crc_q[7:0];
        end
      end
      FCS: begin
        if (cnt_q == 11'd3) begin
          state_d = IFG;
          cnt_d   = 11'd0;
          txd_d   = 8'h00;
          en_d    = 1'b0;
        end else begin
          cnt_d = nxt_idx[10:0];
          txd_d = ~crc_q[{fcs_sel, 3'b000} +: 8];
        end
      end
      IFG: begin
        if (cnt_q == 11'd11) begin
          state_d = IDLE;
          cnt_d   = 11'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = nxt_idx[10:0];
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = 8'h00;
        en_d    = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any frame in flight
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      sync_q  <= 3'b000;
      cnt_q   <= 11'd0;
      len_q   <= 11'd0;
      bank_q  <= 1'b0;
      word_q  <= 10'd0;
      lo_q    <= 8'h00;
      crc_q   <= 32'hFFFF_FFFF;
      txd_q   <= 8'h00;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      bank_q  <= bank_d;
      word_q  <= word_d;
      lo_q    <= lo_d;
      crc_q   <= crc_d;
      txd_q   <= txd_d;
      en_q    <= en_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_mac_tx.sv
// tb_mac_tx: directed scenarios for mac_tx with a 1-cycle-latency frame RAM
// model and a byte collector on the GMII side.
module tb_mac_tx;

  logic        clk = 1'b0;
  logic        RST;
  logic        udp_send;
  logic        rd_bank;
  logic [15:0] frame_len;
  logic [10:0] rdaddr;
  logic [15:0] rd_data;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;
  logic        mac_busy;

  logic [15:0] ram [0:2047];
  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] cap[$];
  int ifg_cnt, idle_bad, bank_bad, maxword;
  logic exp_bank;
  int cyc = 0, fall_cyc = 0, gap = 0;
  logic prev_en = 1'b0;

  always #5 clk = ~clk;

  mac_tx dut (
    .clk(clk), .RST(RST), .udp_send(udp_send), .rd_bank(rd_bank),
    .frame_len(frame_len), .rdaddr(rdaddr), .rd_data(rd_data),
    .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en), .mac_busy(mac_busy)
  );

  // Frame RAM: data appears one cycle after the address
  always @(posedge clk) rd_data <= ram[rdaddr];

  // GMII collector, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (gmii_tx_en === 1'b1) cap.push_back(gmii_txd);
    if (mac_busy === 1'b1 && gmii_tx_en !== 1'b1) ifg_cnt++;
    if (gmii_tx_en !== 1'b1 && gmii_txd !== 8'h00) idle_bad++;
    if (mac_busy === 1'b1 && rdaddr[10] !== exp_bank) bank_bad++;
    if (mac_busy === 1'b1 && int'(rdaddr[9:0]) > maxword) maxword = int'(rdaddr[9:0]);
    if (prev_en && gmii_tx_en !== 1'b1) fall_cyc = cyc;
    if (!prev_en && gmii_tx_en === 1'b1) gap = cyc - fall_cyc - 1;
    prev_en = (gmii_tx_en === 1'b1);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  task automatic clear_cap();
    cap.delete();
    ifg_cnt = 0; idle_bad = 0; bank_bad = 0; maxword = 0;
  endtask

  task automatic fill_pattern(input logic bank, input int kind);
    for (int w = 0; w < 1024; w++) begin
      if (kind == 0) ram[{bank, 10'(w)}] = 16'(w);
      else           ram[{bank, 10'(w)}] = {8'(w * 3 + 1), 8'(w ^ 8'h5A)};
    end
  endtask

  // Raise udp_send, check the 2-edge start latency, then scramble the inputs
  // that must have been latched at start.
  task automatic start_frame(input logic bank, input logic [15:0] len, input string name);
    clear_cap();
    exp_bank = bank;
    @(negedge clk);
    rd_bank = bank; frame_len = len; udp_send = 1'b1;
    @(negedge clk);
    n_checks++;
    if (mac_busy !== 1'b0) begin n_fail++; $display("FAIL %s lat_N: busy=%b want 0", name, mac_busy); end
    @(negedge clk);
    n_checks++;
    if ({mac_busy, gmii_tx_en} !== 2'b00) begin n_fail++; $display("FAIL %s lat_N1: busy/en=%b want 00", name, {mac_busy, gmii_tx_en}); end
    @(negedge clk);
    n_checks++;
    if ({mac_busy, gmii_tx_en, gmii_txd} !== {2'b11, 8'h55}) begin
      n_fail++; $display("FAIL %s lat_N2: busy=%b en=%b txd=%h want 1 1 55", name, mac_busy, gmii_tx_en, gmii_txd);
    end
    rd_bank = ~bank; frame_len = 16'd3;
    repeat (8) @(negedge clk);
    udp_send = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (mac_busy === 1'b0) break;
    end
    n_checks++;
    if (i == 3000) begin n_fail++; $display("FAIL %s done: mac_busy still %b after 3000 cycles, want 0", name, mac_busy); end
  endtask

  task automatic check_frame(input logic bank, input int flen, input string name);
    int L, n, bad, first;
    logic [7:0] exp_q[$];
    logic [31:0] crc;
    logic [15:0] w;
    logic [7:0] b;
    L = (flen > 1514) ? 1514 : flen;
    n = (L < 60) ? 60 : L;
    for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
    exp_q.push_back(8'hD5);
    crc = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      w = ram[{bank, 10'(i / 2)}];
      b = (i >= L) ? 8'h00 : ((i % 2 == 0) ? w[15:8] : w[7:0]);
      exp_q.push_back(b);
      crc = ref_crc(crc, b);
    end
    crc = ~crc;
    for (int i = 0; i < 4; i++) exp_q.push_back(crc[8*i +: 8]);

    n_checks++;
    if (cap.size() != 12 + n) begin n_fail++; $display("FAIL %s tx_en_cycles: got %0d want %0d", name, cap.size(), 12 + n); end
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
      if (cap[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL %s bytes: %0d wrong, first at %0d got %h want %h", name, bad, first, cap[first], exp_q[first]);
    end
    n_checks++;
    if (ifg_cnt != 12) begin n_fail++; $display("FAIL %s ifg: got %0d want 12", name, ifg_cnt); end
    n_checks++;
    if (idle_bad != 0) begin n_fail++; $display("FAIL %s idle_txd: %0d nonzero idle bytes, want 0", name, idle_bad); end
    n_checks++;
    if (bank_bad != 0) begin n_fail++; $display("FAIL %s bank: %0d cycles with rdaddr[10]!=%b", name, bank_bad, bank); end
    n_checks++;
    if (maxword > 756) begin n_fail++; $display("FAIL %s max_word: got %0d want <=756", name, maxword); end
  endtask

  task automatic test_reset();
    RST = 1'b1; udp_send = 1'b0; rd_bank = 1'b0; frame_len = 16'd0;
    for (int i = 0; i < 2048; i++) ram[i] = 16'h0000;
    repeat (2) @(negedge clk);
    n_checks++;
    if (gmii_tx_en !== 1'b0) begin n_fail++; $display("FAIL reset tx_en: got %b want 0", gmii_tx_en); end
    n_checks++;
    if (gmii_txd !== 8'h00) begin n_fail++; $display("FAIL reset txd: got %h want 00", gmii_txd); end
    n_checks++;
    if (mac_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", mac_busy); end
    n_checks++;
    if (rdaddr !== 11'd0) begin n_fail++; $display("FAIL reset rdaddr: got %h want 000", rdaddr); end
    RST = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame_100();
    fill_pattern(1'b1, 0);
    start_frame(1'b1, 16'd100, "len100");
    wait_done("len100");
    check_frame(1'b1, 100, "len100");
  endtask

  task automatic test_short_9();
    ram[0] = 16'h3132; ram[1] = 16'h3334; ram[2] = 16'h3536; ram[3] = 16'h3738; ram[4] = 16'h39AA;
    start_frame(1'b0, 16'd9, "len9");
    wait_done("len9");
    check_frame(1'b0, 9, "len9");
  endtask

  task automatic test_odd_61();
    fill_pattern(1'b0, 1);
    start_frame(1'b0, 16'd61, "len61");
    wait_done("len61");
    check_frame(1'b0, 61, "len61");
    n_checks++;
    if (cap.size() < 69 || cap[68] !== ram[30][15:8]) begin
      n_fail++; $display("FAIL len61 last_byte: got %h want %h", (cap.size() > 68) ? cap[68] : 8'hXX, ram[30][15:8]);
    end
  endtask

  task automatic test_zero_len();
    start_frame(1'b0, 16'd0, "len0");
    wait_done("len0");
    check_frame(1'b0, 0, "len0");
  endtask

  task automatic test_clamp_2000();
    fill_pattern(1'b0, 1);
    start_frame(1'b0, 16'd2000, "len2000");
    wait_done("len2000");
    check_frame(1'b0, 2000, "len2000");
    n_checks++;
    if (maxword != 756) begin n_fail++; $display("FAIL len2000 last_word: got %0d want 756", maxword); end
  endtask

  task automatic test_back_to_back();
    fill_pattern(1'b1, 0);
    start_frame(1'b1, 16'd100, "b2b_a");
    repeat (20) @(negedge clk);
    udp_send = 1'b1;
    repeat (11) @(negedge clk);
    udp_send = 1'b0;
    wait_done("b2b_a");
    check_frame(1'b1, 100, "b2b_a");
    start_frame(1'b1, 16'd100, "b2b_b");
    wait_done("b2b_b");
    check_frame(1'b1, 100, "b2b_b");
    n_checks++;
    if (gap < 12) begin n_fail++; $display("FAIL b2b gap: got %0d idle cycles want >=12", gap); end
  endtask

  task automatic test_reset_mid();
    int i, en_seen;
    fill_pattern(1'b1, 0);
    start_frame(1'b1, 16'd100, "rstmid");
    for (i = 0; i < 200 && cap.size() < 28; i++) @(posedge clk);
    #2 RST = 1'b1;
    #1;
    n_checks++;
    if ({gmii_tx_en, mac_busy, gmii_txd} !== 10'd0) begin
      n_fail++; $display("FAIL rstmid abort: en=%b busy=%b txd=%h want 0 0 00", gmii_tx_en, mac_busy, gmii_txd);
    end
    n_checks++;
    if (rdaddr !== 11'd0) begin n_fail++; $display("FAIL rstmid rdaddr: got %h want 000", rdaddr); end
    @(negedge clk);
    RST = 1'b0;
    en_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (gmii_tx_en !== 1'b0 || mac_busy !== 1'b0) en_seen++;
    end
    n_checks++;
    if (en_seen != 0) begin n_fail++; $display("FAIL rstmid resume: %0d active cycles after release, want 0", en_seen); end
    start_frame(1'b1, 16'd100, "rstmid_new");
    wait_done("rstmid_new");
    check_frame(1'b1, 100, "rstmid_new");
  endtask

  task automatic test_rst_held_send();
    int i, extra;
    ram[0] = 16'h3132; ram[1] = 16'h3334; ram[2] = 16'h3536; ram[3] = 16'h3738; ram[4] = 16'h39AA;
    @(negedge clk);
    clear_cap();
    exp_bank = 1'b0; rd_bank = 1'b0; frame_len = 16'd9;
    udp_send = 1'b1; RST = 1'b1;
    repeat (3) @(negedge clk);
    RST = 1'b0;
    for (i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mac_busy === 1'b1) break;
    end
    n_checks++;
    if (i >= 10) begin n_fail++; $display("FAIL rsthold start: busy=%b after 10 cycles want 1", mac_busy); end
    repeat (6) @(negedge clk);
    udp_send = 1'b0;
    wait_done("rsthold");
    check_frame(1'b0, 9, "rsthold");
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (mac_busy !== 1'b0) extra++;
    end
    n_checks++;
    if (extra != 0) begin n_fail++; $display("FAIL rsthold second_start: busy for %0d cycles want 0", extra); end
  endtask

  initial begin
    test_reset();
    test_frame_100();
    test_short_9();
    test_odd_61();
    test_zero_len();
    test_clamp_2000();
    test_back_to_back();
    test_reset_mid();
    test_rst_held_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tx.md
MAC_TX -- requirements
Module: mac_tx

Interface
REQ-001 SHALL have clk  input  1  system clock; all logic on rising edge.
REQ-002 SHALL have RST  input  1  asynchronous, active-high reset.
REQ-003 SHALL have udp_send  input  1  frame-ready level from the UDP packer, held high about 11 cycles; only its rising edge is used.
REQ-004 SHALL have rd_bank  input  1  RAM half holding the ready frame (packer's ~ping_pong), latched at start.
REQ-005 SHALL have frame_len  input  16  frame bytes from DA through end of payload, excluding preamble/SFD/FCS; latched at start.
REQ-006 SHALL have rdaddr  output  11  frame RAM read address = {bank, word index}.
REQ-007 SHALL have rd_data  input  16  frame RAM read data, valid 1 cycle after rdaddr.
REQ-008 SHALL have gmii_txd  output  8  transmit byte to PHY.
REQ-009 SHALL have gmii_tx_en  output  1  transmit enable to PHY.
REQ-010 SHALL have mac_busy  output  1  high from start until end of IFG.

Function
REQ-011 SHALL synchronise udp_send through 3 flops (s0,s1,s2); start = s1 & !s2, acted on only in IDLE, ignored in all other states.
REQ-012 SHALL implement states IDLE, PREAMBLE, SFD, DATA, PAD, FCS, IFG with transitions in that order, IFG -> IDLE.
REQ-013 IDLE: on start, latch rd_bank and frame_len, set mac_busy=1 and gmii_tx_en=1 on the same edge, enter PREAMBLE.
REQ-014 PREAMBLE: 7 cycles of gmii_txd=0x55; SFD: 1 cycle of 0xD5.
REQ-015 SHALL drive rdaddr={bank,word} and prefetch word 0 during PREAMBLE so DATA starts without a stall; exactly one byte per cycle throughout.
REQ-016 DATA: send bytes 0..L-1, with L=min(frame_len,1514), byte 2k = rd_data[15:8] and byte 2k+1 = rd_data[7:0] of word k; for odd L the final low byte SHALL NOT be sent.
REQ-017 PAD: if L<60, send 0x00 until 60 bytes have been sent; if L>=60, skip PAD.
REQ-018 frame_len=0 SHALL send 60 pad bytes; frame_len>1514 SHALL be clamped to 1514.
REQ-019 SHALL compute CRC-32 (poly 0x04C11DB7, reflected, LSB-first, init 0xFFFFFFFF) over all DATA and PAD bytes, excluding preamble and SFD.
REQ-020 FCS: send ~crc over 4 cycles, bits [7:0] first and [31:24] last; gmii_tx_en stays high through the last FCS byte.
REQ-021 IFG: gmii_tx_en=0 and gmii_txd=0x00 for 12 cycles, then mac_busy=0 and return to IDLE.
REQ-022 Outside PREAMBLE..FCS, gmii_tx_en=0 and gmii_txd=0x00; gmii_tx_en SHALL never drop mid-frame except on RST.
REQ-023 Latency: if udp_send is first sampled high at edge N, the first 0x55 and mac_busy=1 SHALL appear after edge N+2.
REQ-024 Total tx_en-high cycles SHALL equal 8 + max(L,60) + 4.

Reset
REQ-025 RST high SHALL immediately force state=IDLE, gmii_tx_en=0, gmii_txd=0x00, mac_busy=0, rdaddr=0, CRC=0xFFFFFFFF, counters=0, sync flops=0.
REQ-026 RST asserted mid-frame SHALL abort the frame with no FCS, and SHALL NOT resume after release.
REQ-027 After RST release with udp_send already high, one start SHALL be taken, because the sync flops reset to 0.

Verification
REQ-028 frame_len=100, rd_bank=1, RAM words = index -> 55x7, D5, 100 bytes 00 00 00 01 ... in order, rdaddr[10]=1, FCS matching a zlib crc32 reference model, 112 tx_en cycles, 12-cycle IFG.
REQ-029 frame_len=9, bytes "123456789" -> 9 data bytes, 51 bytes 0x00, FCS equal to the reference model of those 60 bytes, 72 tx_en cycles.
REQ-030 frame_len=61 (odd) -> 61 data bytes, last = high byte of word 30, no pad, 73 tx_en cycles.
REQ-031 Second udp_send pulse during DATA -> ignored; a pulse after mac_busy=0 -> a new frame, with at least 12 idle cycles between frames.
REQ-032 RST pulse at data byte 20 -> tx_en=0 at once, mac_busy=0, no FCS; a subsequent udp_send edge -> a complete, correct frame.
REQ-033 frame_len=2000 -> 1514 data bytes, 1526 tx_en cycles, rdaddr word index never exceeds 756.
